uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high: clk is the single clock and rst is synchronous, active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 4 bits: requester i has a byte pending.
REQ-005 The block SHALL have port req_data, input, 32 bits: byte for requester i in bits [8i+7:8i].
REQ-006 The block SHALL have port req_ready, output, 4 bits: one-cycle acknowledge pulse to the accepted requester.
REQ-007 The block SHALL have port tx_start, output, 1 bit: one-cycle start strobe to the shared UART transmitter.
REQ-008 The block SHALL have port tx_data, output, 8 bits: byte presented to the transmitter, held stable from accept until frame end.
REQ-009 The block SHALL have port tx_busy, input, 1 bit: transmitter is serialising.
REQ-010 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse at the end of the transmitter's stop bit.
REQ-011 The block SHALL have port gap_cycles, input, 8 bits: idle cycles inserted between frames, sampled on tx_done.
REQ-012 The block SHALL have port grant_id, output, 2 bits: index of the last accepted requester.
REQ-013 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames, wrapping from 0xFFFF to 0x0000.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set when tx_done is missing; cleared only by rst.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, SEND, WAIT, GAP.
REQ-016 In IDLE with any req_valid bit high, the block SHALL select a requester round-robin, searching from (grant_id+1) mod 4 upward with wrap.
REQ-017 On the edge leaving IDLE, the block SHALL capture req_data of the selected requester into tx_data, load grant_id, and go to SEND.
REQ-018 The block SHALL drive req_ready[grant_id] high for exactly the first cycle in SEND, with all other req_ready bits low.
- Requesters hold valid and data until they see req_ready.
- No second accept is possible until the block is back in IDLE.
REQ-019 In SEND, tx_start SHALL be 1 for one cycle in the first cycle in which tx_busy=0, and the block SHALL then go to WAIT.
- While tx_busy=1, the block stays in SEND.
- Earliest tx_start is 1 cycle after the accept edge, coincident with req_ready.
REQ-020 In WAIT, on tx_done=1 the block SHALL increment frame_cnt.
- If gap_cycles=0, go to IDLE.
- Otherwise load the gap counter with gap_cycles and go to GAP.
REQ-021 GAP SHALL last exactly gap_cycles cycles, decrementing each cycle and exiting to IDLE when the counter equals 1.
- req_valid is ignored in GAP.
REQ-022 A watchdog SHALL count cycles in WAIT; if 1024 cycles pass with no tx_done, the block SHALL set timeout_err and go to IDLE.
- frame_cnt does not increment on a timeout.
- The watchdog is cleared on every entry to WAIT.
REQ-023 tx_done outside WAIT SHALL be ignored.
REQ-024 A change of req_valid after accept SHALL not affect the frame in progress.
REQ-025 A requester that drops req_valid before being granted SHALL lose its turn without error.
REQ-026 The selection SHALL use req_valid as sampled in the IDLE cycle only, with no pre-latched requests.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL go to IDLE and load these values:
- req_ready=0, tx_start=0, tx_data=0x00
- grant_id=3, so requester 0 has first priority
- frame_cnt=0, timeout_err=0
- gap counter and watchdog =0
REQ-028 rst SHALL take priority over every other event, including mid-SEND, WAIT or GAP.
- Any frame in progress is abandoned.
- No req_ready or tx_start is emitted on the reset edge or on the cycle after it.

Verification
REQ-029 Reset check: assert rst for 2 cycles -> all outputs at REQ-027 values; grant_id=3.
REQ-030 Single request: req_valid=4'b0100, req_data[23:16]=0xA5, gap_cycles=0, tx_busy=0 -> next cycle req_ready=4'b0100, tx_start=1, tx_data=0xA5; tx_done 10 cycles later -> frame_cnt=1, back in IDLE.
REQ-031 Fairness: req_valid=4'b1111 held continuously, tx_done returned 5 cycles after each tx_start -> grant order 0,1,2,3,0,1; frame_cnt=6 after six frames.
REQ-032 Gap and busy: gap_cycles=3 with tx_busy=1 on entry to SEND for 4 cycles -> tx_start is delayed until tx_busy=0; after tx_done, exactly 3 GAP cycles before the next accept edge.
REQ-033 Timeout: no tx_done after tx_start -> timeout_err=1 at WAIT cycle 1024; block returns to IDLE; frame_cnt unchanged; the next request is served normally; timeout_err stays 1.
REQ-034 Reset mid-operation: rst pulsed during WAIT with req_valid=4'b0010 held -> REQ-027 values after the edge; accept of requester 1 occurs one cycle after rst deasserts.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that feeds four byte requesters into one
// shared UART transmitter. Each frame flows through accept, start, wait for
// the stop bit, and an optional idle gap. A watchdog abandons any frame
// whose tx_done never arrives.
module uart_tx_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic [7:0]  gap_cycles,
  output logic [1:0]  grant_id,
  output logic [15:0] frame_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t      state_q;
  logic [3:0]  req_ready_q;
  logic [7:0]  tx_data_q;
  logic [1:0]  grant_q;
  logic [15:0] frame_cnt_q;
  logic        timeout_q;
  logic [7:0]  gap_q;
  logic [9:0]  wd_q;

  logic [1:0]  sel_d;
  logic [7:0]  sel_byte;

  // Round-robin pick: scan from grant+4 (lowest priority) down to grant+1
  // (highest priority), so the last hit is the nearest requester after the
  // previous grant.
  always_comb begin
    sel_d = grant_q;
    for (int k = 4; k >= 1; k--) begin
      if (req_valid[grant_q + 2'(k)]) begin
        sel_d = grant_q + 2'(k);
      end
    end
  end

  assign sel_byte = req_data[{sel_d, 3'b000} +: 8];

  // Arbiter FSM: accept, start, wait for the frame end, optional gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      grant_q     <= 2'd3;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
      gap_q       <= '0;
      wd_q        <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            tx_data_q   <= sel_byte;
            grant_q     <= sel_d;
            req_ready_q <= 4'b0001 << sel_d;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            wd_q    <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (gap_cycles == 8'd0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= gap_cycles;
              state_q <= GAP;
            end
          end else if (wd_q == 10'd1023) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 10'd1;
          end
        end
        GAP: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q == 8'd1) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The start strobe has to coincide with the first SEND cycle in which the
  // transmitter is free, so it is decoded from the state register and the
  // live tx_busy rather than registered a cycle late.
  assign tx_start    = (state_q == SEND) && !tx_busy;
  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb. Accepts are
// checked against a scoreboard of expected {grant, byte}. The bench pushes
// each entry when it raises the request, and pops and compares it when
// req_ready pulses.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  gap_cycles;
  logic [1:0]  grant_id;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] g;
    logic [7:0] b;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [7:0]  gap;
    logic [1:0]  exp_g;
    logic [7:0]  exp_b;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vecs[6];

  uart_tx_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .gap_cycles  (gap_cycles),
    .grant_id    (grant_id),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accept pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && req_ready != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_accept", {28'd0, req_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("accept: req_ready=%b grant=%0d data=%02h (exp grant=%0d data=%02h)",
                 req_ready, grant_id, tx_data, e.g, e.b);
        check("sb_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << e.g});
        check("sb_grant", {30'd0, grant_id}, {30'd0, e.g});
        check("sb_data", {24'd0, tx_data}, {24'd0, e.b});
      end
    end
  end

  // Wait (bounded) for a tx_start strobe; returns at the sampling negedge.
  task automatic wait_start(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at the negedge where tx_start was seen: pulse tx_done in WAIT
  // cycle n, optionally dropping the requests on the accept handshake.
  task automatic finish_frame(input int n, input bit drop);
    @(posedge clk); #1;
    if (drop) req_valid = 4'b0000;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_grant"}, {30'd0, grant_id}, 32'd3);
    check({tag, "_cnt"}, {16'd0, frame_cnt}, 32'd0);
    check({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    vecs[0] = '{4'b0100, 32'h00A50000, 8'd0, 2'd2, 8'hA5, 16'd1};
    vecs[1] = '{4'b1111, 32'h44332211, 8'd0, 2'd3, 8'h44, 16'd2};
    vecs[2] = '{4'b0110, 32'h5A6B7C8D, 8'd0, 2'd1, 8'h7C, 16'd3};
    vecs[3] = '{4'b0001, 32'hFFEEDDC3, 8'd1, 2'd0, 8'hC3, 16'd4};
    vecs[4] = '{4'b1010, 32'h12345678, 8'd0, 2'd1, 8'h56, 16'd5};
    vecs[5] = '{4'b1000, 32'h9ABCDEF0, 8'd2, 2'd3, 8'h9A, 16'd6};

    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    tx_done = 1'b0; gap_cycles = '0;

    // Reset state after two reset cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Table-driven single frames: round-robin order, byte capture, gap.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid  = vecs[i].valid;
      req_data   = vecs[i].data;
      gap_cycles = vecs[i].gap;
      sb.push_back('{vecs[i].exp_g, vecs[i].exp_b});
      wait_start($sformatf("vec%0d", i));
      finish_frame(10, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_cnt", i), {16'd0, frame_cnt}, {16'd0, vecs[i].exp_cnt});
    end

    // Fairness: all four held, grant order 0,1,2,3,0,1.
    @(posedge clk); #1;
    gap_cycles = 8'd0;
    req_data   = 32'hD4C3B2A1;
    req_valid  = 4'b1111;
    sb.push_back('{2'd0, 8'hA1}); sb.push_back('{2'd1, 8'hB2});
    sb.push_back('{2'd2, 8'hC3}); sb.push_back('{2'd3, 8'hD4});
    sb.push_back('{2'd0, 8'hA1}); sb.push_back('{2'd1, 8'hB2});
    for (int i = 0; i < 6; i++) begin
      wait_start($sformatf("fair%0d", i));
      finish_frame(5, i == 5);
    end
    @(negedge clk);
    check("fair_cnt", {16'd0, frame_cnt}, 32'd12);

    // Busy hold and gap length.
    @(posedge clk); #1;
    tx_busy    = 1'b1;
    gap_cycles = 8'd3;
    req_data   = 32'h00003CB7;
    req_valid  = 4'b0001;
    sb.push_back('{2'd0, 8'hB7});
    sb.push_back('{2'd1, 8'h3C});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) break;
      n++;
    end
    check("busy_accept_lat", n, 1);
    check("busy_hold1", {31'd0, tx_start}, 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("ready_one_cycle", {28'd0, req_ready}, 32'd0);
    check("busy_hold2", {31'd0, tx_start}, 32'd0);
    for (int i = 3; i <= 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("busy_hold%0d", i), {31'd0, tx_start}, 32'd0);
    end
    @(posedge clk); #1;
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy_release", {31'd0, tx_start}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done    = 1'b0;
    gap_cycles = 8'd0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) break;
      n++;
    end
    // Three GAP cycles plus the IDLE cycle in which the accept is decided.
    check("gap_len", n, 4);
    check("gap_start", {31'd0, tx_start}, 32'd1);
    finish_frame(4, 1'b1);
    @(negedge clk);
    check("gap_cnt", {16'd0, frame_cnt}, 32'd14);

    // Watchdog timeout.
    @(posedge clk); #1;
    req_data  = 32'h00E10000;
    req_valid = 4'b0100;
    sb.push_back('{2'd2, 8'hE1});
    wait_start("tmo");
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (1023) @(posedge clk);
    @(negedge clk);
    check("tmo_before", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tmo_set", {31'd0, timeout_err}, 32'd1);
    check("tmo_cnt", {16'd0, frame_cnt}, 32'd14);
    @(posedge clk); #1;
    req_data  = 32'h7F000000;
    req_valid = 4'b1000;
    sb.push_back('{2'd3, 8'h7F});
    wait_start("after_tmo");
    finish_frame(2, 1'b1);
    @(negedge clk);
    check("after_tmo_cnt", {16'd0, frame_cnt}, 32'd15);
    check("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // tx_done outside WAIT is ignored.
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("stray_done_cnt", {16'd0, frame_cnt}, 32'd15);

    // Reset during WAIT with requester 1 still asking.
    @(posedge clk); #1;
    req_data  = 32'h00006600;
    req_valid = 4'b0010;
    sb.push_back('{2'd1, 8'h66});
    sb.push_back('{2'd1, 8'h66});
    wait_start("rst_mid");
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(negedge clk);
    check("rst_reaccept", {28'd0, req_ready}, 32'b0010);
    check("rst_restart", {31'd0, tx_start}, 32'd1);
    finish_frame(3, 1'b1);
    @(negedge clk);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
